// File: rtl/bpm_pkg.sv
// Shared constants for the heart-rate calculator: sample rate, divider
// geometry, output width and FSM state encoding.
package bpm_pkg;

    localparam int SAMPLE_RATE_HZ = 25;
    localparam int BPM_NUM        = 60 * SAMPLE_RATE_HZ;
    localparam int NUM_W          = 11;
    localparam int CNT_W          = 6;
    localparam int BPM_W          = 8;
    localparam int STEP_W         = $clog2(NUM_W);

    localparam logic [BPM_W-1:0] BPM_SAT = {BPM_W{1'b1}};

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_DIV      = 2'b01;
    localparam logic [1:0] ST_WAIT_LOW = 2'b11;

endpackage

// File: rtl/seq_divider.sv
// Bit-serial restoring divider: NUM_W enabled steps, MSB first, one quotient
// bit per step. The final quotient is offered combinationally on the last step.
import bpm_pkg::*;

module seq_divider (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             last_step,
    output logic [NUM_W-1:0] quotient_next
);

    localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_W - 1);

    logic [NUM_W-1:0]  dvd_q;
    logic [NUM_W-1:0]  quo_q;
    logic [CNT_W-1:0]  dvs_q;
    logic [CNT_W-1:0]  rem_q;
    logic [STEP_W-1:0] step_q;

    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    diff;
    logic              fits;
    logic [CNT_W-1:0]  rem_next;

    // The remainder is always below the 6-bit divisor, so it fits back in CNT_W bits.
    always_comb begin
        trial         = {rem_q, dvd_q[NUM_W-1]};
        diff          = trial - {1'b0, dvs_q};
        fits          = (trial >= {1'b0, dvs_q});
        rem_next      = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        quotient_next = {quo_q[NUM_W-2:0], fits};
        last_step     = busy && (step_q == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the datapath is reset too, so it never holds X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            step_q <= '0;
            busy   <= 1'b0;
        end else if (en) begin
            if (start) begin
                dvd_q  <= dividend;
                dvs_q  <= divisor;
                quo_q  <= '0;
                rem_q  <= '0;
                step_q <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                dvd_q  <= {dvd_q[NUM_W-2:0], 1'b0};
                quo_q  <= quotient_next;
                rem_q  <= rem_next;
                step_q <= step_q + 1'b1;
                if (last_step) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bpm_calc.sv
// Converts a peak-to-peak interval (sample ticks) into beats per minute,
// saturating to BPM_W bits and handshaking with the interval counter.
import bpm_pkg::*;

module bpm_calc (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid,
    input  logic [CNT_W-1:0] time_counter,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_err,
    output logic             BPMCalc_Done
);

    logic [1:0]       state_q;
    logic             start;
    logic             busy;
    logic             last_step;
    logic [NUM_W-1:0] quotient_next;

    always_comb begin
        start = (state_q == ST_IDLE) && valid && (time_counter != '0);
    end

    seq_divider u_div (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .start         (start),
        .dividend      (NUM_W'(BPM_NUM)),
        .divisor       (time_counter),
        .busy          (busy),
        .last_step     (last_step),
        .quotient_next (quotient_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bpm          <= '0;
            bpm_err      <= 1'b0;
            BPMCalc_Done <= 1'b0;
        end else if (en) begin
            BPMCalc_Done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        if (time_counter != '0) begin
                            state_q <= ST_DIV;
                        end else begin
                            bpm          <= '0;
                            bpm_err      <= 1'b1;
                            BPMCalc_Done <= 1'b1;
                            state_q      <= ST_WAIT_LOW;
                        end
                    end
                end
                ST_DIV: begin
                    if (last_step) begin
                        // Any quotient bit above BPM_W means the rate cannot be shown.
                        if (|quotient_next[NUM_W-1:BPM_W]) begin
                            bpm     <= BPM_SAT;
                            bpm_err <= 1'b1;
                        end else begin
                            bpm     <= quotient_next[BPM_W-1:0];
                            bpm_err <= 1'b0;
                        end
                        BPMCalc_Done <= 1'b1;
                        state_q      <= ST_WAIT_LOW;
                    end else if (!busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
